trigger_capture: RTL
====================

# trigger_capture

Triggered sample-capture stage between the ADC channel outputs and the VGA waveform renderer. Decimates the incoming sample stream, detects a level/slope trigger with auto-timeout, and captures one screen-width record (with pre-trigger history) into a double-buffered RAM. Completed records swap to the display bank only on a frame boundary, so the renderer indexes a stable record by screen X without tearing.

## Interface
- DATA_W, 12, sample width
- DEPTH, 640, samples per record (one per screen column)
- ADDR_W, 10, RAM address width (2^ADDR_W ≥ DEPTH)
- PRETRIG, 64, samples kept before the trigger point (< DEPTH)
- AUTO_TIMEOUT, 4096, accepted samples without trigger before auto-mode forces one
---
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- sample_valid  in  1  one-cycle strobe, new ADC sample
- sample_data  in  DATA_W  ADC sample, unsigned
- arm  in  1  capture enable; low forces IDLE
- trig_level  in  DATA_W  trigger threshold
- trig_slope  in  1  0 = rising, 1 = falling
- trig_auto  in  1  1 = auto mode (timeout forces trigger), 0 = normal
- decim  in  4  keep one sample in every 2^decim (0..15)
- frame_sync  in  1  one-cycle pulse at start of vertical blanking
- rd_x  in  11  screen column requested by renderer
- rd_data  out  DATA_W  display-bank sample for rd_x
- frame_ready  out  1  one-cycle pulse when banks swap
- triggered  out  1  high while displayed record came from a true trigger (low if forced)
- busy  out  1  high in any state except IDLE

## Operation
- Accepted sample: sample_valid high and decimation counter == 0; counter counts sample_valid strobes modulo 2^decim, reset to 0 on leaving IDLE.
- Write bank is a ring indexed by wr_ptr (0..DEPTH-1, wraps DEPTH-1 → 0); each accepted sample written at wr_ptr, then wr_ptr increments.
- States:
  - IDLE: no writes. arm high → PREFILL, wr_ptr = 0, fill = 0.
  - PREFILL: write; fill counts to PRETRIG, then → WAIT_TRIG. No trigger detection here.
  - WAIT_TRIG: write; detect on each accepted sample against previous accepted sample. Rising: prev < level and cur ≥ level. Falling: prev > level and cur ≤ level. On hit → POST, record start = (wr_ptr − PRETRIG) mod DEPTH (wr_ptr of triggering sample), is_true = 1. Auto mode: timeout counter of accepted samples reaching AUTO_TIMEOUT forces same transition with is_true = 0; counter clears on entry.
  - POST: write DEPTH − PRETRIG samples including triggering one → HOLD.
  - HOLD: no writes; on frame_sync: swap banks, latch start and is_true into display side, pulse frame_ready, → PREFILL (arm high) or IDLE.
- Read: address = (disp_start + rd_x) mod DEPTH; rd_x ≥ DEPTH → rd_data = 0.
- arm low in any state → IDLE next cycle; display bank and its start untouched.

## Timing
- Reset: state IDLE, wr_ptr 0, bank select 0, disp_start 0, rd_data 0, frame_ready 0, triggered 0, busy 0. RAM contents undefined (display shows garbage until first swap; acceptable).
- rd_data latency: 1 cycle after rd_x (registered RAM read; modulo add combinational).
- Trigger detection uses data registered on the accepted-sample cycle; transition to POST on the following clock.
- frame_sync coincident with the final POST write: not honoured; swap waits for the next frame_sync after HOLD is entered.
- frame_sync during HOLD with arm falling same cycle: arm wins, no swap.
- Modulo arithmetic: ADDR_W+1-bit sum, subtract DEPTH if ≥ DEPTH (no divider).
- Minimum record period: DEPTH accepted samples plus wait for frame_sync.

## Structure
- Shared package: state encoding (IDLE, PREFILL, WAIT_TRIG, POST, HOLD), DATA_W default, DEPTH, screen-width constant shared with renderer.
- One sub-module: capture_ram_dp — simple dual-port RAM, 2·DEPTH words, write port from FSM, registered read port; bank select is address MSB.

## Test plan
- Ramp 0..4095 step 8, level 2048, rising, decim 0 → trigger at sample 256; after frame_sync, rd_x=64 returns 2048, rd_x=0 returns 1536, triggered = 1, one frame_ready pulse.
- Same ramp, trig_slope 1 → no trigger; trig_auto 1 → forced after 4096 accepted samples, triggered = 0; trig_auto 0 → stays WAIT_TRIG, no swap.
- decim 2 with sample_valid every cycle → writes every 4th sample; rd_x=1 − rd_x=0 equals 4× input step.
- Capture completes, frame_sync withheld 10000 cycles → display unchanged, busy high; first frame_sync → swap with one-cycle frame_ready.
- arm dropped mid-POST → IDLE next cycle, rd_data still previous record, busy 0.
- rd_x = 640 and 2047 → rd_data 0; reset asserted mid-WAIT_TRIG → all outputs at reset values next cycle.

Source files
------------

// File: rtl/trigger_capture_pkg.sv
// Shared constants, state encoding and ring-address helpers for the triggered
// capture stage and the waveform renderer.
package trigger_capture_pkg;

  localparam int DATA_W       = 12;
  localparam int DEPTH        = 640;
  localparam int ADDR_W       = 10;
  localparam int PRETRIG      = 64;
  localparam int AUTO_TIMEOUT = 4096;
  localparam int SCREEN_W     = DEPTH;
  localparam int X_W          = 11;

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_HOLD      = 3'd4
  } cap_state_e;

  // (a + b) mod DEPTH for a < DEPTH and b < DEPTH, using one conditional subtract
  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W:0]   b);
    logic [ADDR_W:0] sum_s;
    sum_s = {1'b0, a} + b;
    if (sum_s >= DEPTH_X) begin
      sum_s = sum_s - DEPTH_X;
    end else begin
      sum_s = sum_s;
    end
    return sum_s[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] ring_back_pretrig(input logic [ADDR_W-1:0] ptr);
    return mod_add(ptr, (ADDR_W+1)'(DEPTH - PRETRIG));
  endfunction

endpackage

// File: rtl/trigger_capture_if.sv
// Sample stream, trigger controls and renderer read port of the capture stage.
interface trigger_capture_if;
  import trigger_capture_pkg::*;

  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              arm;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic              trig_auto;
  logic [3:0]        decim;
  logic              frame_sync;
  logic [X_W-1:0]    rd_x;
  logic [DATA_W-1:0] rd_data;
  logic              frame_ready;
  logic              triggered;
  logic              busy;

  modport master (
    output sample_valid, sample_data, arm, trig_level, trig_slope, trig_auto,
           decim, frame_sync, rd_x,
    input  rd_data, frame_ready, triggered, busy
  );

  modport slave (
    input  sample_valid, sample_data, arm, trig_level, trig_slope, trig_auto,
           decim, frame_sync, rd_x,
    output rd_data, frame_ready, triggered, busy
  );

endinterface

// File: rtl/trigger_capture_ram_dp.sv
// Two-bank simple dual-port sample RAM; address MSB selects the bank,
// read data is registered.
module capture_ram_dp
  import trigger_capture_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [DATA_W-1:0] rd_q
);

  logic [DATA_W-1:0] mem_r [2][DEPTH];

  // write port from the capture FSM, registered read port for the renderer
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr[ADDR_W]][wr_addr[ADDR_W-1:0]] <= wr_data;
    end
    rd_q <= mem_r[rd_addr[ADDR_W]][rd_addr[ADDR_W-1:0]];
  end

endmodule

// File: rtl/trigger_capture.sv
// Decimate, trigger, capture one screen-wide record with pre-trigger history,
// and swap it to the display bank on a frame boundary.
module trigger_capture
  import trigger_capture_pkg::*;
(
  input logic              clock,
  input logic              reset,
  trigger_capture_if.slave bus
);

  localparam int FILL_W = $clog2(PRETRIG + 1);
  localparam int TMO_W  = $clog2(AUTO_TIMEOUT);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);
  localparam logic [X_W-1:0]    X_LIMIT   = X_W'(SCREEN_W);

  cap_state_e        state_r, state_nx_s;
  logic [ADDR_W-1:0] wr_ptr_r, post_cnt_r, start_r, disp_start_r;
  logic [FILL_W-1:0] fill_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [14:0]       dec_cnt_r, dec_mask_s;
  logic [DATA_W-1:0] prev_r, ram_q_s;
  logic              is_true_r, wr_bank_r, triggered_r, frame_ready_r, busy_r, rd_zero_r;
  logic              accept_s, writing_s, hit_s, force_s, fire_s, swap_s;

  assign dec_mask_s = 15'((16'd1 << bus.decim) - 16'd1);
  assign accept_s   = bus.sample_valid && (dec_cnt_r == 15'd0);
  assign writing_s  = accept_s && ((state_r == ST_PREFILL) || (state_r == ST_WAIT_TRIG) ||
                                   (state_r == ST_POST));
  assign hit_s      = bus.trig_slope ? ((prev_r > bus.trig_level) && (bus.sample_data <= bus.trig_level))
                                     : ((prev_r < bus.trig_level) && (bus.sample_data >= bus.trig_level));
  assign force_s    = bus.trig_auto && (tmo_cnt_r == TMO_LAST);
  assign fire_s     = (state_r == ST_WAIT_TRIG) && accept_s && (hit_s || force_s);
  // arm low suppresses the swap even when frame_sync arrives in HOLD
  assign swap_s     = (state_r == ST_HOLD) && bus.arm && bus.frame_sync;

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    if (!bus.arm) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:      state_nx_s = ST_PREFILL;
        ST_PREFILL:   state_nx_s = (accept_s && (fill_r == FILL_LAST)) ? ST_WAIT_TRIG : ST_PREFILL;
        ST_WAIT_TRIG: state_nx_s = fire_s ? ST_POST : ST_WAIT_TRIG;
        ST_POST:      state_nx_s = (accept_s && (post_cnt_r == POST_LAST)) ? ST_HOLD : ST_POST;
        ST_HOLD:      state_nx_s = bus.frame_sync ? ST_PREFILL : ST_HOLD;
        default:      state_nx_s = ST_IDLE;
      endcase
    end
  end

  // FSM state, capture counters, bank swap and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      wr_ptr_r      <= ADDR_W'(0);
      post_cnt_r    <= ADDR_W'(0);
      start_r       <= ADDR_W'(0);
      disp_start_r  <= ADDR_W'(0);
      fill_r        <= FILL_W'(0);
      tmo_cnt_r     <= TMO_W'(0);
      dec_cnt_r     <= 15'd0;
      prev_r        <= DATA_W'(0);
      is_true_r     <= 1'b0;
      wr_bank_r     <= 1'b0;
      triggered_r   <= 1'b0;
      frame_ready_r <= 1'b0;
      busy_r        <= 1'b0;
      rd_zero_r     <= 1'b1;
    end else begin
      state_r       <= state_nx_s;
      busy_r        <= (state_nx_s != ST_IDLE);
      frame_ready_r <= swap_s;
      rd_zero_r     <= (bus.rd_x >= X_LIMIT);

      if ((state_r == ST_IDLE) || swap_s) begin
        wr_ptr_r <= ADDR_W'(0);
        fill_r   <= FILL_W'(0);
      end else begin
        if (writing_s) begin
          wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? ADDR_W'(0) : wr_ptr_r + ADDR_W'(1);
          prev_r   <= bus.sample_data;
        end
        if ((state_r == ST_PREFILL) && accept_s) begin
          fill_r <= fill_r + FILL_W'(1);
        end
      end

      if (state_r == ST_IDLE) begin
        dec_cnt_r <= 15'd0;
      end else if (bus.sample_valid) begin
        dec_cnt_r <= (dec_cnt_r + 15'd1) & dec_mask_s;
      end

      if (state_r != ST_WAIT_TRIG) begin
        tmo_cnt_r <= TMO_W'(0);
      end else if (accept_s) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end

      // the triggering sample was written in WAIT_TRIG, so POST starts at one
      if (state_r != ST_POST) begin
        post_cnt_r <= ADDR_W'(1);
      end else if (accept_s) begin
        post_cnt_r <= post_cnt_r + ADDR_W'(1);
      end

      if (fire_s) begin
        start_r   <= ring_back_pretrig(wr_ptr_r);
        is_true_r <= hit_s;
      end

      if (swap_s) begin
        wr_bank_r    <= ~wr_bank_r;
        disp_start_r <= start_r;
        triggered_r  <= is_true_r;
      end
    end
  end

  capture_ram_dp u_ram (
    .clock   (clock),
    .wr_en   (writing_s),
    .wr_addr ({wr_bank_r, wr_ptr_r}),
    .wr_data (bus.sample_data),
    .rd_addr ({~wr_bank_r, mod_add(disp_start_r, bus.rd_x)}),
    .rd_q    (ram_q_s)
  );

  assign bus.rd_data     = rd_zero_r ? DATA_W'(0) : ram_q_s;
  assign bus.frame_ready = frame_ready_r;
  assign bus.triggered   = triggered_r;
  assign bus.busy        = busy_r;

endmodule
